// File: rtl/inst_buffer.sv
// -----------------------------------------------------------------------------
// inst_buffer
//   Per-warp instruction buffer sitting between Fetch and the issue scheduler
//   of one SM. Fetch delivers up to two packets per cycle for one warp; each
//   warp owns a small circular FIFO. The scheduler reads the head packet of
//   the warp it selects and may consume it.
//
// Ports
//   clk                 clock, all state on rising edge
//   reset               asynchronous active-low reset
//   stall_i             freezes pushes and pops (flush still applies)
//   instWarp_i          warp owning this cycle's fetched packets
//   instPacket0Valid_i  packet 0 (older) valid
//   instPacket0_i       packet 0
//   instPacket1Valid_i  packet 1 (younger) valid, ignored without packet 0
//   instPacket1_i       packet 1
//   flush_i             discard all entries of flushWarp_i
//   flushWarp_i         warp to flush
//   issueValid_i        scheduler consumes head of issueWarp_i
//   issueWarp_i         warp being read/consumed
//   warpValidVector_o   bit w: warp w has at least two free entries
//   readyVector_o       bit w: warp w FIFO non-empty
//   issuePacketValid_o  readyVector_o[issueWarp_i]
//   issuePacket_o       head entry of issueWarp_i
//   overflow_o          sticky: a packet was dropped for lack of space
// -----------------------------------------------------------------------------

// Single-warp circular FIFO with dual-entry push and single pop.
module ib_warp_fifo #(
  parameter int DEPTH     = 4,
  parameter int DEPTH_LOG = 2,
  parameter int PKT_W     = 64,
  parameter int CW        = DEPTH_LOG + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,     // this warp owns the fetch slot (not stalled)
  input  logic             pkt0_v_i,
  input  logic             pkt1_v_i,
  input  logic [PKT_W-1:0] pkt0_i,
  input  logic [PKT_W-1:0] pkt1_i,
  input  logic             pop_i,      // consume request for this warp (not stalled)
  input  logic             flush_i,
  output logic [CW-1:0]    count_o,
  output logic [PKT_W-1:0] head_pkt_o,
  output logic             drop_o      // a packet was refused this cycle
);

  logic [DEPTH-1:0][PKT_W-1:0] mem_q;
  logic [DEPTH_LOG-1:0]        head_q, head_d, tail_q, tail_d, tail_p1;
  logic [CW-1:0]               count_q, count_d;
  logic [CW-1:0]               live, room, req, acc;
  logic                        pop;

  always_comb begin
    pop     = pop_i && (count_q != '0);
    // Space is judged after this cycle's pop has freed its slot.
    live    = count_q - CW'(pop);
    room    = CW'(DEPTH) - live;
    req     = '0;
    if (push_i && pkt0_v_i) req = pkt1_v_i ? CW'(2) : CW'(1);
    // Accept in order until full; the younger packet is the one dropped.
    acc     = (req > room) ? room : req;
    drop_o  = push_i && !flush_i && (req > room);
    tail_p1 = tail_q + 1'b1;
    head_d  = head_q + DEPTH_LOG'(pop);
    tail_d  = tail_q + DEPTH_LOG'(acc);
    count_d = live + acc;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; occupancy is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (acc >= CW'(1)) mem_q[tail_q]  <= pkt0_i;
      if (acc == CW'(2)) mem_q[tail_p1] <= pkt1_i;
    end
  end

  assign count_o    = count_q;
  assign head_pkt_o = mem_q[head_q];

endmodule

module inst_buffer #(
  parameter int NUM_WARP     = 8,
  parameter int NUM_WARP_LOG = 3,
  parameter int DEPTH        = 4,
  parameter int DEPTH_LOG    = 2,
  parameter int PKT_W        = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall_i,
  input  logic [NUM_WARP_LOG-1:0] instWarp_i,
  input  logic                    instPacket0Valid_i,
  input  logic [PKT_W-1:0]        instPacket0_i,
  input  logic                    instPacket1Valid_i,
  input  logic [PKT_W-1:0]        instPacket1_i,
  input  logic                    flush_i,
  input  logic [NUM_WARP_LOG-1:0] flushWarp_i,
  input  logic                    issueValid_i,
  input  logic [NUM_WARP_LOG-1:0] issueWarp_i,
  output logic [NUM_WARP-1:0]     warpValidVector_o,
  output logic [NUM_WARP-1:0]     readyVector_o,
  output logic                    issuePacketValid_o,
  output logic [PKT_W-1:0]        issuePacket_o,
  output logic                    overflow_o
);

  localparam int CW = DEPTH_LOG + 1;

  logic [NUM_WARP-1:0][CW-1:0]    count;
  logic [NUM_WARP-1:0][PKT_W-1:0] head_pkt;
  logic [NUM_WARP-1:0]            drop;
  logic                           overflow_q, overflow_d;

  for (genvar w = 0; w < NUM_WARP; w++) begin : g_warp
    logic sel_push, sel_pop, sel_flush;
    assign sel_push  = !stall_i && (instWarp_i == NUM_WARP_LOG'(w));
    assign sel_pop   = !stall_i && issueValid_i && (issueWarp_i == NUM_WARP_LOG'(w));
    assign sel_flush = flush_i && (flushWarp_i == NUM_WARP_LOG'(w));

    ib_warp_fifo #(
      .DEPTH     (DEPTH),
      .DEPTH_LOG (DEPTH_LOG),
      .PKT_W     (PKT_W),
      .CW        (CW)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (sel_push),
      .pkt0_v_i   (instPacket0Valid_i),
      .pkt1_v_i   (instPacket1Valid_i),
      .pkt0_i     (instPacket0_i),
      .pkt1_i     (instPacket1_i),
      .pop_i      (sel_pop),
      .flush_i    (sel_flush),
      .count_o    (count[w]),
      .head_pkt_o (head_pkt[w]),
      .drop_o     (drop[w])
    );

    assign warpValidVector_o[w] = (count[w] <= CW'(DEPTH - 2));
    assign readyVector_o[w]     = (count[w] != '0);
  end

  assign overflow_d = overflow_q | (|drop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign overflow_o         = overflow_q;
  assign issuePacketValid_o = readyVector_o[issueWarp_i];
  assign issuePacket_o      = head_pkt[issueWarp_i];

endmodule
